// File: rtl/enemy_wave_engine.sv
// Enemy-wave controller and sprite renderer.
// Each frame: erase every active enemy box, advance the enemies, redraw them
// through the sprite mask, then test the bottom edge. One pixel per clock
// goes to the VGA plot port. Frame timing is paced by a tick divider.
module enemy_wave_engine #(
  parameter int                         MAX_EN   = 10,
  parameter int                         SPR_W    = 5,
  parameter int                         SPR_H    = 5,
  parameter logic [SPR_W*SPR_H-1:0]     SPR_MASK = 25'h0047C84,
  parameter int                         SCREEN_H = 120,
  parameter int                         TICK_DIV = 1666667
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [3:0]            enemy_count,
  input  logic [1:0]            flying_rate,
  input  logic [8*MAX_EN-1:0]   x_base,
  input  logic [MAX_EN-1:0]     destroy,
  output logic [7:0]            vga_x,
  output logic [7:0]            vga_y,
  output logic [2:0]            vga_colour,
  output logic                  vga_plot,
  output logic                  busy,
  output logic                  game_over
);

  localparam int SW = (MAX_EN > 1) ? $clog2(MAX_EN) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int PW = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERASE = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_OVER  = 3'd6;

  logic [2:0]        state_q;
  logic [SW-1:0]     slot_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [PW-1:0]     pix_q;     // row*SPR_W+col, kept alongside row/col to index the mask
  logic [TW-1:0]     tick_q;
  logic [7:0]        y_q [MAX_EN];
  logic [MAX_EN-1:0] alive_q;
  logic [MAX_EN-1:0] pend_q;

  logic              scanning;
  logic              scan_last;
  logic [7:0]        sel_x;
  logic [7:0]        sel_y;
  logic              sel_alive;
  logic              edge_hit;
  logic [3:0]        n_clamped;
  logic [MAX_EN-1:0] alive_load;

  // Select the slot under the scan counters and evaluate the bottom-edge test.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_x     = '0;
    sel_y     = '0;
    sel_alive = 1'b0;
    edge_hit  = 1'b0;
    for (int i = 0; i < MAX_EN; i++) begin
      if (slot_q == SW'(i)) begin
        sel_x     = x_base[8*i +: 8];
        sel_y     = y_q[i];
        sel_alive = alive_q[i];
      end
      if (alive_q[i] && (10'(y_q[i]) + 10'(SPR_H) >= 10'(SCREEN_H)))
        edge_hit = 1'b1;
    end
  end

  // Wave size on start: clamp to the number of slots, enable the low n slots.
  always_comb begin
    n_clamped  = (enemy_count > 4'(MAX_EN)) ? 4'(MAX_EN) : enemy_count;
    alive_load = '0;
    for (int i = 0; i < MAX_EN; i++)
      alive_load[i] = (4'(i) < n_clamped);
  end

  assign scanning  = (state_q == S_ERASE) || (state_q == S_DRAW);
  assign scan_last = (slot_q == SW'(MAX_EN - 1)) && (row_q == RW'(SPR_H - 1)) &&
                     (col_q == CW'(SPR_W - 1));

  // Pixel port: coordinates only shown while scanning so idle outputs read 0.
  assign vga_plot   = scanning && sel_alive && ((state_q == S_ERASE) || SPR_MASK[pix_q]);
  assign vga_x      = scanning ? sel_x + 8'(col_q) : 8'd0;
  assign vga_y      = scanning ? sel_y + 8'(row_q) : 8'd0;
  assign vga_colour = (state_q == S_DRAW) ? 3'b111 : 3'b000;
  assign busy       = scanning || (state_q == S_MOVE) || (state_q == S_CHECK);
  assign game_over  = (state_q == S_OVER);

  // Frame sequencer, scan counters, enemy positions and pending destroys.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (!reset_n) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= '0;
      tick_q  <= '0;
      alive_q <= '0;
      pend_q  <= '0;
      // NOTE: the position array is a handful of flops, not a RAM, so it is reset like any register.
      for (int i = 0; i < MAX_EN; i++) y_q[i] <= '0;
    end else begin
      // Destroy requests latch in any state; inactive slots cannot hold one.
      pend_q <= pend_q | (destroy & alive_q);
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q <= S_DRAW;
            alive_q <= alive_load;
            pend_q  <= '0;
            slot_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
            for (int i = 0; i < MAX_EN; i++) y_q[i] <= '0;
          end
        end
        S_ERASE, S_DRAW: begin
          if (scan_last) begin
            state_q <= (state_q == S_ERASE) ? S_MOVE : S_CHECK;
            slot_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
          end else if (col_q == CW'(SPR_W - 1)) begin
            col_q <= '0;
            if (row_q == RW'(SPR_H - 1)) begin
              row_q  <= '0;
              pix_q  <= '0;
              slot_q <= slot_q + 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
              pix_q <= pix_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
            pix_q <= pix_q + 1'b1;
          end
        end
        S_MOVE: begin
          // Destroyed enemies respawn at the top; the rest fall by flying_rate.
          for (int i = 0; i < MAX_EN; i++) begin
            if (alive_q[i]) begin
              if (pend_q[i]) y_q[i] <= '0;
              else           y_q[i] <= y_q[i] + 8'(flying_rate);
            end
          end
          pend_q  <= destroy & alive_q;
          state_q <= S_DRAW;
        end
        S_CHECK: begin
          state_q <= edge_hit ? S_OVER : S_WAIT;
          tick_q  <= '0;
        end
        S_WAIT: begin
          if (tick_q == TW'(TICK_DIV - 1)) state_q <= S_ERASE;
          else                             tick_q  <= tick_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_wave_engine.sv
// Scoreboard bench for enemy_wave_engine: a bench-side wave model pushes the
// expected pixel stream for each pass; a monitor pops and compares every plot.
module tb_enemy_wave_engine;

  localparam int          MAX_EN   = 3;
  localparam int          SPR_W    = 5;
  localparam int          SPR_H    = 5;
  localparam int          SCREEN_H = 20;
  localparam int          TICK_DIV = 4;
  localparam int          PASS     = MAX_EN * SPR_W * SPR_H;
  localparam logic [24:0] MASK     = 25'h0047C84;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic [3:0]           enemy_count;
  logic [1:0]           flying_rate;
  logic [8*MAX_EN-1:0]  x_base;
  logic [MAX_EN-1:0]    destroy;
  logic [7:0]           vga_x;
  logic [7:0]           vga_y;
  logic [2:0]           vga_colour;
  logic                 vga_plot;
  logic                 busy;
  logic                 game_over;

  enemy_wave_engine #(
    .MAX_EN(MAX_EN), .SPR_W(SPR_W), .SPR_H(SPR_H), .SPR_MASK(MASK),
    .SCREEN_H(SCREEN_H), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .enemy_count(enemy_count),
    .flying_rate(flying_rate), .x_base(x_base), .destroy(destroy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_en   = 1'b0;
  logic [18:0] exp_q [$];          // {x, y, colour} per expected plot

  // Bench model of the wave
  logic [7:0]        ym [MAX_EN];
  logic [MAX_EN-1:0] am;
  logic [MAX_EN-1:0] pm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Every plot the DUT emits must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en && vga_plot === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_plot", 32'(vga_plot), 32'd0);
      else                   check("plot", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
    end
  end

  task automatic push_pass(input bit draw);
    for (int s = 0; s < MAX_EN; s++)
      for (int r = 0; r < SPR_H; r++)
        for (int c = 0; c < SPR_W; c++)
          if (am[s] && (!draw || MASK[r*SPR_W + c]))
            exp_q.push_back({x_base[8*s +: 8] + 8'(c), ym[s] + 8'(r), draw ? 3'b111 : 3'b000});
  endtask

  task automatic model_move();
    for (int s = 0; s < MAX_EN; s++)
      if (am[s]) begin
        if (pm[s]) begin ym[s] = 8'd0; pm[s] = 1'b0; end
        else ym[s] = ym[s] + 8'(flying_rate);
      end
  endtask

  function automatic bit model_over();
    bit o = 1'b0;
    for (int s = 0; s < MAX_EN; s++)
      if (am[s] && (int'(ym[s]) + SPR_H >= SCREEN_H)) o = 1'b1;
    return o;
  endfunction

  // Pulse start; leaves the bench 1 ns after the edge that entered DRAW.
  task automatic start_wave(input logic [3:0] cnt);
    int n;
    @(posedge clk); #1;
    start = 1'b1;
    enemy_count = cnt;
    n = (int'(cnt) > MAX_EN) ? MAX_EN : int'(cnt);
    for (int s = 0; s < MAX_EN; s++) begin
      am[s] = (s < n);
      ym[s] = 8'd0;
    end
    pm = '0;
    push_pass(1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("game_over_cleared", 32'(game_over), 32'd0);
  endtask

  // One frame from DRAW cycle 0: DRAW, CHECK, WAIT, ERASE, MOVE.
  // dmask is pulsed mid-DRAW together with an (ignored) start; abort_at >= 0
  // pulls reset at that ERASE cycle.
  task automatic run_frame(input logic [MAX_EN-1:0] dmask, input int abort_at, output bit over);
    over = 1'b0;
    for (int i = 0; i < PASS; i++) begin
      if (i == 30) begin
        destroy = dmask; start = 1'b1; enemy_count = 4'd1;
        pm = pm | (dmask & am);
      end else if (i == 31) begin
        destroy = '0; start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("draw_drained", 32'(exp_q.size()), 32'd0);
    check("busy_in_check", 32'(busy), 32'd1);
    @(posedge clk); #1;
    over = model_over();
    check("game_over", 32'(game_over), 32'(over));
    check("busy_after_check", 32'(busy), 32'd0);
    if (over) return;
    push_pass(1'b0);
    repeat (TICK_DIV) @(posedge clk);
    #1;
    check("busy_in_erase", 32'(busy), 32'd1);
    for (int i = 0; i < PASS; i++) begin
      if (i == abort_at) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        over = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    check("erase_drained", 32'(exp_q.size()), 32'd0);
    check("busy_in_move", 32'(busy), 32'd1);
    model_move();
    push_pass(1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_plot"},   32'(vga_plot),   32'd0);
    check({tag, "_x"},      32'(vga_x),      32'd0);
    check({tag, "_y"},      32'(vga_y),      32'd0);
    check({tag, "_colour"}, 32'(vga_colour), 32'd0);
    check({tag, "_busy"},   32'(busy),       32'd0);
    check({tag, "_over"},   32'(game_over),  32'd0);
  endtask

  initial begin
    logic [MAX_EN-1:0] dm [7];
    bit over;
    int frames;
    reset_n = 1'b0; start = 1'b0; enemy_count = 4'd0; flying_rate = 2'd0;
    x_base = {8'd0, 8'd40, 8'd10}; destroy = '0;
    am = '0; pm = '0;
    for (int s = 0; s < MAX_EN; s++) ym[s] = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Two enemies falling by 3 until slot rows reach 15 and the edge trips
    flying_rate = 2'd3;
    start_wave(4'd2);
    frames = 0;
    over = 1'b0;
    while (!over && frames < 10) begin
      run_frame('0, -1, over);
      frames++;
    end
    check("frames_to_over", 32'(frames), 32'd6);
    repeat (20) @(posedge clk);
    #1;
    check("over_held", 32'(game_over), 32'd1);
    check("over_not_busy", 32'(busy), 32'd0);

    // Restart from OVER, destroy slot1 at y=3 and slot0 at y=12, rate 0 once
    start_wave(4'd2);
    dm = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    for (int f = 0; f < 7; f++) begin
      flying_rate = (f == 5) ? 2'd0 : 2'd3;
      run_frame(dm[f], -1, over);
      check("no_over_in_destroy_frames", 32'(over), 32'd0);
    end

    // Reset mid-DRAW, then clamped wave aborted by reset mid-ERASE
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    check_idle_outputs("reset_mid_draw");
    flying_rate = 2'd1;
    start_wave(4'd12);
    run_frame('0, 20, over);
    check_idle_outputs("reset_mid_erase");
    repeat (5) @(posedge clk);
    #1;
    check("final_drained", 32'(exp_q.size()), 32'd0);
    check("final_idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
